// File: rtl/mem_pkg.sv
// Shared memory-side encodings for the data cache controller
// and the future icache arbiter.
package mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [1:0] IO_HI_REGION = 2'b11;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_ISSUE,
        DC_DRAIN,
        DC_DONE
    } dc_state_t;

    // Index of the final byte of an access; width 3 behaves as a word.
    function automatic logic [1:0] last_cnt(input logic [1:0] width);
        logic [1:0] r;
        case (width)
            WIDTH_BYTE: r = 2'd0;
            WIDTH_HALF: r = 2'd1;
            default:    r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_controller_load_extender.sv
// Merges an in-flight read byte into the assembly word and
// sign/zero-extends the result to 32 bits.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] asm_val,
    input  logic        pend,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] ext_val
);

    always_comb begin
        merged = asm_val;
        if (pend) begin
            merged[{lane, 3'b000} +: 8] = din;
        end
    end

    always_comb begin
        ext_val = merged;
        case (width)
            WIDTH_BYTE: ext_val = {{24{sign_ext & merged[7]}}, merged[7:0]};
            WIDTH_HALF: ext_val = {{16{sign_ext & merged[15]}}, merged[15:0]};
            default:    ext_val = merged;
        endcase
    end

endmodule

// File: rtl/dcache_controller.sv
// Byte-serial load/store unit between the LSB and the memory arbiter.
// Optional DCACHE_MISALIGN_CHECK_EN aborts on misaligned or width-3 requests.
module dcache_controller
    import mem_pkg::*;
#(
    parameter int         ADDR_W = 18,
    parameter logic [1:0] IO_HI  = IO_HI_REGION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hci_rdy,
    input  logic              dcache_rw_en,
    input  logic              dcache_write_mode,
    input  logic [1:0]        dcache_width,
    input  logic              dcache_sign_ext,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [31:0]       dcache_value,
    output logic              dcache_idle,
    output logic              dcache_rw_feedback_en,
    output logic [31:0]       dcache_load_val,
    input  logic              io_buffer_full,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din
);

    dc_state_t         state;
    dc_state_t         state_n;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        width_q;
    logic              mode_q;
    logic              sext_q;
    logic [31:0]       value_q;
    logic [31:0]       asm_q;
    logic              pend_q;
    logic [1:0]        lane_q;
    logic [31:0]       load_val_q;

    logic              accept;
    logic              io_stall;
    logic              is_last;
    logic [31:0]       merged;
    logic [31:0]       ext_val;

    assign accept = hci_rdy && dcache_rw_en &&
                    (state == DC_IDLE || state == DC_DONE);

    // Only stores into the IO window back-pressure on the IO sink.
    assign io_stall = mode_q && (addr_q[ADDR_W-1 -: 2] == IO_HI) &&
                      io_buffer_full;

    assign is_last = (cnt == last_cnt(width_q));

    assign mem_en   = hci_rdy && (state == DC_ISSUE) && !io_stall;
    assign mem_wr   = (state == DC_ISSUE) && mode_q;
    assign mem_a    = (state == DC_ISSUE) ? addr_q + ADDR_W'(cnt) : '0;
    assign mem_dout = (state == DC_ISSUE) ? value_q[{cnt, 3'b000} +: 8]
                                          : 8'h00;

    assign dcache_idle           = (state == DC_IDLE);
    assign dcache_rw_feedback_en = (state == DC_DONE);
    assign dcache_load_val       = load_val_q;

    load_extender u_ext (
        .asm_val  (asm_q),
        .pend     (pend_q),
        .lane     (lane_q),
        .din      (mem_din),
        .width    (width_q),
        .sign_ext (sext_q),
        .merged   (merged),
        .ext_val  (ext_val)
    );

    always_comb begin
        state_n = state;
        if (hci_rdy) begin
            case (state)
                DC_IDLE: begin
                    if (accept) state_n = DC_ISSUE;
                end
                DC_ISSUE: begin
                    if (mem_en && is_last) begin
                        state_n = mode_q ? DC_DONE : DC_DRAIN;
                    end
                end
                DC_DRAIN: state_n = DC_DONE;
                DC_DONE:  state_n = accept ? DC_ISSUE : DC_IDLE;
                default:  state_n = DC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DC_IDLE;
            cnt        <= 2'd0;
            addr_q     <= '0;
            width_q    <= WIDTH_BYTE;
            mode_q     <= 1'b0;
            sext_q     <= 1'b0;
            value_q    <= 32'h0;
            asm_q      <= 32'h0;
            pend_q     <= 1'b0;
            lane_q     <= 2'd0;
            load_val_q <= 32'h0;
        end else begin
            state <= state_n;
            // Read bytes land regardless of hci_rdy on the following edge.
            asm_q  <= merged;
            pend_q <= mem_en && !mode_q;
            lane_q <= cnt;
            if (accept) begin
                addr_q  <= dcache_addr;
                width_q <= dcache_width;
                mode_q  <= dcache_write_mode;
                sext_q  <= dcache_sign_ext;
                value_q <= dcache_value;
                cnt     <= 2'd0;
            end else if (mem_en) begin
                cnt <= cnt + 2'd1;
            end
            if (hci_rdy && state == DC_DRAIN) begin
                load_val_q <= ext_val;
            end
        end
    end

`ifdef DCACHE_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            if ((dcache_width == WIDTH_HALF && dcache_addr[0]) ||
                (dcache_width == WIDTH_WORD && dcache_addr[1:0] != 2'b00) ||
                (dcache_width == 2'd3)) begin
                $fatal(1, "dcache misaligned access addr=%h width=%0d",
                       dcache_addr, dcache_width);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed requests, queued
// expectations, monitor compares every memory strobe and feedback pulse.
module tb_dcache_controller;

    logic        clk;
    logic        rst;
    logic        hci_rdy;
    logic        dcache_rw_en;
    logic        dcache_write_mode;
    logic [1:0]  dcache_width;
    logic        dcache_sign_ext;
    logic [17:0] dcache_addr;
    logic [31:0] dcache_value;
    logic        dcache_idle;
    logic        dcache_rw_feedback_en;
    logic [31:0] dcache_load_val;
    logic        io_buffer_full;
    logic        mem_en;
    logic        mem_wr;
    logic [17:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    dcache_controller dut (
        .clk                   (clk),
        .rst                   (rst),
        .hci_rdy               (hci_rdy),
        .dcache_rw_en          (dcache_rw_en),
        .dcache_write_mode     (dcache_write_mode),
        .dcache_width          (dcache_width),
        .dcache_sign_ext       (dcache_sign_ext),
        .dcache_addr           (dcache_addr),
        .dcache_value          (dcache_value),
        .dcache_idle           (dcache_idle),
        .dcache_rw_feedback_en (dcache_rw_feedback_en),
        .dcache_load_val       (dcache_load_val),
        .io_buffer_full        (io_buffer_full),
        .mem_en                (mem_en),
        .mem_wr                (mem_wr),
        .mem_a                 (mem_a),
        .mem_dout              (mem_dout),
        .mem_din               (mem_din)
    );

    typedef struct {
        int          cyc;
        logic        wr;
        logic [17:0] a;
        logic [7:0]  d;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        ld;
        logic [31:0] v;
    } fb_exp_t;

    mem_exp_t mem_q[$];
    fb_exp_t  fb_q[$];
    mem_exp_t me;
    fb_exp_t  fe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c;
    int c1;

    bit [7:0] ram [0:262143];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_wr === 1'b1) ram[mem_a] <= mem_dout;
        if (mem_en === 1'b1 && mem_wr === 1'b0) mem_din <= ram[mem_a];
        else mem_din <= 8'hA5;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input int cy, input logic wr, input logic [17:0] a,
                           input logic [7:0] d);
        mem_exp_t e;
        e.cyc = cy; e.wr = wr; e.a = a; e.d = d;
        mem_q.push_back(e);
    endtask

    task automatic exp_fb(input int cy, input logic ld, input logic [31:0] v);
        fb_exp_t e;
        e.cyc = cy; e.ld = ld; e.v = v;
        fb_q.push_back(e);
    endtask

    task automatic req(input logic wr, input logic [1:0] w, input logic sx,
                       input logic [17:0] a, input logic [31:0] v);
        dcache_rw_en      = 1'b1;
        dcache_write_mode = wr;
        dcache_width      = w;
        dcache_sign_ext   = sx;
        dcache_addr       = a;
        dcache_value      = v;
        @(posedge clk); #1;
        dcache_rw_en      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((mem_q.size() != 0 || fb_q.size() != 0 ||
                dcache_idle !== 1'b1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending mem, %0d pending fb, expected 0",
                     name, mem_q.size(), fb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every strobe and pulse must match the head of its queue.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got cyc %0d a %h wr %b, expected none",
                         cyc, mem_a, mem_wr);
            end else begin
                me = mem_q.pop_front();
                if (me.cyc != cyc || mem_wr !== me.wr ||
                    mem_a !== me.a || mem_dout !== me.d) begin
                    errors++;
                    $display("FAIL mem_access: got cyc %0d wr %b a %h d %h, expected cyc %0d wr %b a %h d %h",
                             cyc, mem_wr, mem_a, mem_dout,
                             me.cyc, me.wr, me.a, me.d);
                end
            end
        end
        if (dcache_rw_feedback_en === 1'b1) begin
            checks++;
            if (fb_q.size() == 0) begin
                errors++;
                $display("FAIL fb_unexpected: got pulse at cyc %0d, expected none", cyc);
            end else begin
                fe = fb_q.pop_front();
                if (fe.cyc != cyc || (fe.ld && dcache_load_val !== fe.v)) begin
                    errors++;
                    $display("FAIL feedback: got cyc %0d val %h, expected cyc %0d val %h",
                             cyc, dcache_load_val, fe.cyc, fe.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        hci_rdy = 1'b1;
        dcache_rw_en = 1'b0;
        dcache_write_mode = 1'b0;
        dcache_width = 2'd0;
        dcache_sign_ext = 1'b0;
        dcache_addr = 18'h0;
        dcache_value = 32'h0;
        io_buffer_full = 1'b0;
        ram[18'h00104] = 8'h11;
        ram[18'h00105] = 8'h22;
        ram[18'h00106] = 8'h33;
        ram[18'h00107] = 8'h44;
        ram[18'h00200] = 8'h80;
        ram[18'h00202] = 8'h80;
        ram[18'h00203] = 8'hFF;
        ram[18'h3FFFF] = 8'h34;
        ram[18'h00000] = 8'h92;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", 32'(dcache_idle), 32'd1);
        chk("rst_fb", 32'(dcache_rw_feedback_en), 32'd0);
        chk("rst_load_val", dcache_load_val, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // lw 0x104
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h00104, 8'h00);
        exp_mem(c + 2, 1'b0, 18'h00105, 8'h00);
        exp_mem(c + 3, 1'b0, 18'h00106, 8'h00);
        exp_mem(c + 4, 1'b0, 18'h00107, 8'h00);
        exp_fb(c + 6, 1'b1, 32'h44332211);
        req(1'b0, 2'd2, 1'b0, 18'h00104, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            chk("lw_busy", 32'(dcache_idle), 32'd0);
            @(posedge clk); #1;
        end
        chk("lw_idle_after", 32'(dcache_idle), 32'd1);
        wait_idle("lw");

        // lb signed 0x200
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h00200, 8'h00);
        exp_fb(c + 3, 1'b1, 32'hFFFFFF80);
        req(1'b0, 2'd0, 1'b1, 18'h00200, 32'h0);
        wait_idle("lb");

        // lhu 0x202
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h00202, 8'h00);
        exp_mem(c + 2, 1'b0, 18'h00203, 8'h00);
        exp_fb(c + 4, 1'b1, 32'h0000FF80);
        req(1'b0, 2'd1, 1'b0, 18'h00202, 32'h0);
        wait_idle("lhu");
        chk("load_val_hold", dcache_load_val, 32'h0000FF80);

        // sw then lw accepted in the DONE cycle
        c = cyc;
        c1 = c + 5;
        exp_mem(c + 1, 1'b1, 18'h00010, 8'hEF);
        exp_mem(c + 2, 1'b1, 18'h00011, 8'hBE);
        exp_mem(c + 3, 1'b1, 18'h00012, 8'hAD);
        exp_mem(c + 4, 1'b1, 18'h00013, 8'hDE);
        exp_fb(c + 5, 1'b0, 32'h0);
        exp_mem(c1 + 1, 1'b0, 18'h00010, 8'h00);
        exp_mem(c1 + 2, 1'b0, 18'h00011, 8'h00);
        exp_mem(c1 + 3, 1'b0, 18'h00012, 8'h00);
        exp_mem(c1 + 4, 1'b0, 18'h00013, 8'h00);
        exp_fb(c1 + 6, 1'b1, 32'hDEADBEEF);
        req(1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF);
        repeat (4) @(posedge clk);
        #1;
        chk("sw_done_fb", 32'(dcache_rw_feedback_en), 32'd1);
        chk("sw_done_busy", 32'(dcache_idle), 32'd0);
        req(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
        chk("b2b_no_gap", 32'(dcache_idle), 32'd0);
        wait_idle("sw_lw");

        // sb to IO with the sink full for 3 cycles
        c = cyc;
        exp_mem(c + 4, 1'b1, 18'h30000, 8'h41);
        exp_fb(c + 5, 1'b0, 32'h0);
        io_buffer_full = 1'b1;
        req(1'b1, 2'd0, 1'b0, 18'h30000, 32'h00000041);
        repeat (3) @(posedge clk);
        #1;
        io_buffer_full = 1'b0;
        wait_idle("io_stall");

        // signed half across the address wrap; loads ignore io_buffer_full
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h3FFFF, 8'h00);
        exp_mem(c + 2, 1'b0, 18'h00000, 8'h00);
        exp_fb(c + 4, 1'b1, 32'hFFFF9234);
        io_buffer_full = 1'b1;
        req(1'b0, 2'd1, 1'b1, 18'h3FFFF, 32'h0);
        wait_idle("lh_wrap");
        io_buffer_full = 1'b0;

        // lw with hci_rdy low for 2 cycles after byte 1
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h00104, 8'h00);
        exp_mem(c + 4, 1'b0, 18'h00105, 8'h00);
        exp_mem(c + 5, 1'b0, 18'h00106, 8'h00);
        exp_mem(c + 6, 1'b0, 18'h00107, 8'h00);
        exp_fb(c + 8, 1'b1, 32'h44332211);
        req(1'b0, 2'd2, 1'b0, 18'h00104, 32'h0);
        @(posedge clk); #1;
        hci_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hci_rdy = 1'b1;
        wait_idle("hci_stall");

        // reset during byte 2 of a word load
        c = cyc;
        exp_mem(c + 1, 1'b0, 18'h00104, 8'h00);
        exp_mem(c + 2, 1'b0, 18'h00105, 8'h00);
        req(1'b0, 2'd2, 1'b0, 18'h00104, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", 32'(dcache_idle), 32'd1);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_fb", 32'(dcache_rw_feedback_en), 32'd0);
        chk("abort_load_val", dcache_load_val, 32'h0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_mem_left", 32'(mem_q.size()), 32'd0);
        chk("abort_fb_left", 32'(fb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Byte-serial data-memory access unit directly downstream of the load/store buffer.
- Accepts one load/store request at a time (byte/half/word, 18-bit address) and splits it into byte accesses on the shared byte-wide RAM/IO port through the memory arbiter.
- Load results are reassembled with sign/zero extension and returned to the LSB with a 1-cycle feedback pulse.
- Accepts a new request in the same cycle it pulses feedback, so the LSB can stream back-to-back operations.

Parameters:
- ADDR_W, 18, request/memory address width.
- IO_HI, 2'b11, value of addr[17:16] that selects the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hci_rdy  in  1  global run enable; low freezes the block
- dcache_rw_en  in  1  request valid from LSB
- dcache_write_mode  in  1  1 = store, 0 = load
- dcache_width  in  2  0 = byte, 1 = half, 2 = word
- dcache_sign_ext  in  1  load sign-extend flag
- dcache_addr  in  18  byte address
- dcache_value  in  32  store data; low bytes used first
- dcache_idle  out  1  high only in IDLE
- dcache_rw_feedback_en  out  1  1-cycle done pulse (load and store)
- dcache_load_val  out  32  extended load result, valid with feedback
- io_buffer_full  in  1  IO write sink cannot accept
- mem_en  out  1  byte access strobe to arbiter
- mem_wr  out  1  1 = write byte
- mem_a  out  18  byte address
- mem_dout  out  8  write byte
- mem_din  in  8  read byte, valid the cycle after its mem_en read

Behaviour:
- Reset: state IDLE. dcache_idle=1. feedback_en=0, load_val=0, mem_en=0, mem_wr=0, mem_a=0, mem_dout=0. Byte counter and assembly register cleared. Reset mid-operation aborts it with no feedback.
- States: IDLE, ISSUE, DRAIN, DONE. Byte count N = 1/2/4 for width 0/1/2; width 3 is illegal.
- Acceptance: a request is latched (addr, width, mode, sign_ext, value) when dcache_rw_en=1 in IDLE or DONE; next state ISSUE with cnt=0. A request in any other state is ignored; the LSB never issues one.
- ISSUE:
  - mem_en=1, mem_a=addr+cnt (18-bit wrap), mem_wr=mode, mem_dout=value[8*cnt+7:8*cnt].
  - cnt increments each issuing cycle.
  - After the byte with cnt=N-1: a store goes to DONE; a load goes to DRAIN.
- Load capture: the byte issued in cycle t is captured from mem_din in cycle t+1 into byte lane cnt_of_t of the assembly register. A pending flag tracks the lane.
- DRAIN: captures the final byte, then goes to DONE.
- DONE:
  - feedback_en=1 for exactly one cycle.
  - load_val = assembled value, sign- or zero-extended from 8/16 bits; word is unchanged. Extension is computed on the DRAIN→DONE edge.
  - If a new request is accepted, next state is ISSUE; otherwise IDLE.
- Latency from the accept edge: load feedback at cycle N+2 (lb=3, lh=4, lw=6); store at cycle N+1 (sb=2, sw=5).
- Outside DONE: feedback_en=0 and load_val holds its last value.
- IO stall: in ISSUE, with mode=store, addr[17:16]==IO_HI and io_buffer_full=1, mem_en=0 and cnt is held. Loads are never stalled by io_buffer_full.
- hci_rdy=0: every register holds and mem_en is forced 0. A read byte whose mem_en cycle had hci_rdy=1 is still captured on the following edge; the pending flag is registered, not gated. Issue resumes at the same cnt.
- mem_a wraps modulo 2^18; no carry into the upper bits.

Optional Feature:
- Macro DCACHE_MISALIGN_CHECK_EN.
  - Defined: accepting a half at an odd address, a word with addr[1:0]!=0, or width 3 triggers $fatal with address and width.
  - Undefined: these requests are processed byte-serially as normal, with no check; width 3 is treated as word.

Decomposition:
- Shared package mem_pkg:
  - width encodings WIDTH_BYTE/HALF/WORD.
  - IO_HI region constant.
  - state enum DC_IDLE/ISSUE/DRAIN/DONE, reused by the future icache arbiter.
- Natural sub-module load_extender: combinational 32-bit assemble and extend from width and sign_ext.

Test Plan:
- lw at 0x00104, RAM bytes 11,22,33,44 → mem_a 0x104..0x107 in cycles 1-4; feedback at cycle 6 with load_val 0x44332211; dcache_idle=0 in cycles 1-6.
- lb sign_ext=1 at 0x00200 holding 0x80 → 0xFFFFFF80 at cycle 3. lhu at 0x00202 holding 0x80,0xFF → 0x0000FF80.
- sw 0xDEADBEEF at 0x00010 with a new lw accepted during its DONE cycle → mem_dout EF,BE,AD,DE; lw ISSUE starts in the next cycle with no IDLE gap.
- sb 0x41 to 0x30000 with io_buffer_full high for 3 cycles → no mem_en for 3 cycles, then one write; feedback one cycle later.
- lw with hci_rdy dropped for 2 cycles after byte 1 → byte 1 still captured; issue resumes at byte 2; correct value, feedback 2 cycles late.
- rst asserted during word-load byte 2 → next cycle IDLE, mem_en=0, no feedback pulse ever.
